// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, 2*WIDTH-bit dividend / WIDTH-bit divisor.
// Latency: done in the cycle after edge N+WIDTH (normal) or N+1 (zero divisor/overflow), N = accept edge.
// Backpressure: start is sampled only in IDLE; requests while busy/done are dropped, never queued.
// Ports: clk, rst_n (async, active low), start, dividend, divisor -> busy, done,
//        quotient, remainder, div_by_zero, overflow, chk_err.
// Optional self-check enabled by macro SEQ_DIVIDER_CHECK_EN (chk_err tied 0 otherwise).
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow,
  output logic               chk_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] dlo;     // low dividend half, consumed MSB first
  logic [WIDTH-1:0] dsr;     // captured divisor
  logic [WIDTH-1:0] p;       // partial remainder
  logic [WIDTH-1:0] qacc;    // quotient bits produced so far
  logic [CW-1:0]    cnt;     // index of the quotient bit being produced
  logic             fz;      // pending zero-divisor result
  logic             fo;      // pending overflow result

  logic [WIDTH:0]   t;
  logic             ge;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] q_next;

  // One restoring step. The compare is W+1 bits wide; the subtract can be
  // done modulo 2^W because p < dsr guarantees t - dsr < dsr.
  always_comb begin
    t      = {p, dlo[cnt]};
    ge     = (t >= {1'b0, dsr});
    p_next = ge ? (t[WIDTH-1:0] - dsr) : t[WIDTH-1:0];
    q_next = qacc;
    q_next[cnt] = ge;
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

`ifdef SEQ_DIVIDER_CHECK_EN
  logic [WIDTH-1:0]   dhi;
  logic [2*WIDTH-1:0] recon;
  // Rebuild the dividend from the result being registered so that chk_err
  // is valid in the same cycle as done.
  assign recon = ({{WIDTH{1'b0}}, q_next} * {{WIDTH{1'b0}}, dsr})
               + {{WIDTH{1'b0}}, p_next};
`else
  assign chk_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dlo         <= '0;
      dsr         <= '0;
      p           <= '0;
      qacc        <= '0;
      cnt         <= '0;
      fz          <= 1'b0;
      fo          <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
`ifdef SEQ_DIVIDER_CHECK_EN
      dhi         <= '0;
      chk_err     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dlo         <= dividend[WIDTH-1:0];
            dsr         <= divisor;
            p           <= dividend[2*WIDTH-1:WIDTH];
            qacc        <= '0;
            cnt         <= CW'(WIDTH - 1);
            fz          <= (divisor == '0);
            fo          <= (divisor != '0) && (dividend[2*WIDTH-1:WIDTH] >= divisor);
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
`ifdef SEQ_DIVIDER_CHECK_EN
            dhi         <= dividend[2*WIDTH-1:WIDTH];
            chk_err     <= 1'b0;
`endif
            state       <= CALC;
          end
        end
        CALC: begin
          if (fz || fo) begin
            // Flagged results spend a single busy cycle, no iteration.
            quotient    <= '1;
            remainder   <= fz ? dlo : '0;
            div_by_zero <= fz;
            overflow    <= fo;
            state       <= DONE;
          end else begin
            p    <= p_next;
            qacc <= q_next;
            cnt  <= cnt - 1'b1;
            if (cnt == '0) begin
              quotient  <= q_next;
              remainder <= p_next;
`ifdef SEQ_DIVIDER_CHECK_EN
              chk_err   <= (recon != {dhi, dlo});
`endif
              state     <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=4): stimulus pushes hand-computed
// expectations, an independent monitor pops one per done pulse and compares.
module tb_seq_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       overflow;
  logic       chk_err;

  seq_divider #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .chk_err     (chk_err)
  );

  typedef struct {
    int       id;
    logic [3:0] q;
    logic [3:0] r;
    logic     z;
    logic     o;
    int       acc;
    int       lat;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   next_id = 1;
  logic prev_done = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int id, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s (op %0d): got %0d, expected %0d", name, id, act, req);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        if (prev_done) check("done_one_cycle", 0, 1, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 0, 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("quotient",    e.id, int'(quotient),    int'(e.q));
          check("remainder",   e.id, int'(remainder),   int'(e.r));
          check("div_by_zero", e.id, int'(div_by_zero), int'(e.z));
          check("overflow",    e.id, int'(overflow),    int'(e.o));
          check("chk_err",     e.id, int'(chk_err),     0);
          check("busy_in_done",e.id, int'(busy),        0);
          check("latency",     e.id, cyc - e.acc,       e.lat);
        end
      end
      prev_done = done;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 0, 1, 0);
  endtask

  // Issue one request; push the expected result unless push==0.
  task automatic issue(input logic [7:0] a, input logic [3:0] b,
                       input logic [3:0] eq, input logic [3:0] er,
                       input logic ez, input logic eo, input bit push);
    exp_t e;
    wait_idle();
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    if (push) begin
      e.id  = next_id;
      e.q   = eq;
      e.r   = er;
      e.z   = ez;
      e.o   = eo;
      e.acc = cyc + 1;
      e.lat = (ez || eo) ? 1 : 4;
      exp_q.push_back(e);
    end
    next_id++;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom_range(0, 255);
    divisor  = 4'($urandom_range(0, 15));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  0, int'(busy),        0);
    check({tag, "_done"},  0, int'(done),        0);
    check({tag, "_quot"},  0, int'(quotient),    0);
    check({tag, "_rem"},   0, int'(remainder),   0);
    check({tag, "_dbz"},   0, int'(div_by_zero), 0);
    check({tag, "_ovf"},   0, int'(overflow),    0);
    check({tag, "_chk"},   0, int'(chk_err),     0);
  endtask

  initial begin
    int n;
    rst_n    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #3 rst_n = 1'b0;
    #1 check_all_zero("reset");
    // start high during reset must not be accepted
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    issue(8'd156, 4'd13, 4'd12, 4'd0,  1'b0, 1'b0, 1'b1);
    issue(8'd157, 4'd13, 4'd12, 4'd1,  1'b0, 1'b0, 1'b1);
    issue(8'd200, 4'd0,  4'd15, 4'd8,  1'b1, 1'b0, 1'b1);
    issue(8'd208, 4'd13, 4'd15, 4'd0,  1'b0, 1'b1, 1'b1);
    issue(8'd255, 4'd15, 4'd15, 4'd0,  1'b0, 1'b1, 1'b1);
    issue(8'd14,  4'd3,  4'd4,  4'd2,  1'b0, 1'b0, 1'b1);
    issue(8'd239, 4'd15, 4'd15, 4'd14, 1'b0, 1'b0, 1'b1);

    // Second request during the 2nd busy cycle must be dropped.
    issue(8'd100, 4'd7,  4'd14, 4'd2,  1'b0, 1'b0, 1'b1);
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 4'd5;
    @(negedge clk);
    start    = 1'b0;

    // Reset in the middle of CALC discards the operation.
    issue(8'd157, 4'd13, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_all_zero("mid_calc_reset");
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'd99, 4'd9, 4'd11, 4'd0, 1'b0, 1'b0, 1'b1);

    n = 0;
    while ((exp_q.size() != 0 || busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("pending_results", 0, exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
